ber_run_sequencer: RTL and testbench
====================================

Name: ber_run_sequencer

Overview:
- Run controller for the parallel multi-core BER/FEC simulation system.
- On start it resets the system and streams a probability table into it over the probability_idx/probability_in write port.
- It then enables the system until a frame-count or frame-error limit is reached, or abort is asserted.
- After a drain period it snapshots the error counters for host readout.

Parameters:
N_ENTRIES, 64, number of probability table entries loaded per run
TBL_AW, 6, table read address width (>= clog2(N_ENTRIES))
CLR_CYCLES, 4, cycles sys_rstn is held low in CLEAR
DRAIN_CYCLES, 16, cycles after sys_en drops before counters are snapshotted

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; ignored while busy
abort  in  1  terminate current run
frame_limit  in  64  stop when total_frames >= value; 0 disables this limit
err_limit  in  64  stop when total_frame_errors >= value; 0 disables this limit
tbl_addr  out  TBL_AW  probability table read address
tbl_rd_data  in  64  table data; valid 1 cycle after tbl_addr
probability_idx  out  32  system table write index; all-ones = no write
probability_in  out  64  system table write data
sys_en  out  1  system enable
sys_rstn  out  1  system reset, active low
total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors  in  64 each  live system counters
res_bits, res_err_pre, res_err_post, res_frames, res_frame_err  out  64 each  snapshotted results
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when results are valid
aborted  out  1  last run ended by abort; cleared on start

Behaviour:
- Reset values: probability_idx=32'hFFFFFFFF, probability_in=0, sys_en=0, sys_rstn=0, tbl_addr=0, busy=0, done=0, aborted=0, all res_*=0. State=IDLE.
- All outputs are registered.
- States: IDLE, CLEAR, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - sys_rstn=1, sys_en=0.
  - start -> latch frame_limit/err_limit, clear aborted, go to CLEAR.
- CLEAR:
  - sys_rstn=0 for exactly CLR_CYCLES cycles, then go to LOAD with sys_rstn=1.
- LOAD:
  - tbl_addr steps 0..N_ENTRIES-1, one address per cycle.
  - The cycle after address k is issued: probability_idx=k and probability_in=tbl_rd_data.
  - The cycle after entry N_ENTRIES-1 is written: probability_idx returns to all-ones and the state goes to RUN. LOAD lasts N_ENTRIES+1 cycles.
  - probability_idx is all-ones in every state other than LOAD write cycles.
- RUN:
  - sys_en=1.
  - Stop condition: (frame_limit!=0 && total_frames>=frame_limit) || (err_limit!=0 && total_frame_errors>=err_limit) || abort.
  - The stop condition is evaluated each cycle on the input counters. When true, sys_en=0 on the next cycle and the state goes to DRAIN.
  - Both limits 0 -> run until abort.
- DRAIN:
  - sys_en=0 for DRAIN_CYCLES cycles; the system is not reset.
  - On the last cycle, capture all five counters into res_*.
- DONE: done=1 for one cycle, then go to IDLE. res_* hold until the next DONE; they are not cleared by start.
- abort handling:
  - In CLEAR or LOAD: immediately go to IDLE, set aborted=1, probability_idx=all-ones. res_* are unchanged and done is not pulsed.
  - In RUN: set aborted=1 and take the normal DRAIN/DONE path, so res_* are updated and done pulses.
  - In DRAIN or DONE: ignored.
- start and abort in the same IDLE cycle: start wins; abort is ignored.
- Asynchronous reset mid-run: all outputs return to their reset values immediately, including sys_rstn=0, which resets the system.
- Limit comparisons are unsigned 64-bit.

Test Plan:
- Reset, then start with table[i]=i*3, limits 1000/0 -> sys_rstn low exactly 4 cycles. Writes idx=0..63 with data 0,3,..,189 on consecutive cycles, then idx=FFFFFFFF. sys_en rises the cycle after the last write.
- RUN with a counter model incrementing total_frames by 1 per cycle, frame_limit=1000 -> sys_en falls the cycle after total_frames reaches 1000. done pulses 16+1 cycles later; res_frames equals the counter value at the snapshot.
- frame_limit=0, err_limit=5, total_frame_errors steps to 5 at cycle 300 -> stop. aborted=0, res_frame_err=5.
- abort at LOAD entry 20 -> IDLE next cycle, aborted=1, no done pulse, res_* retain previous values, probability_idx=FFFFFFFF.
- Both limits 0, abort after 500 RUN cycles -> DRAIN, done pulse, aborted=1. A start pulse during DRAIN is ignored; no second run occurs.
- Assert rstn low mid-RUN -> sys_en=0, sys_rstn=0, busy=0 asynchronously. After release, a fresh start performs a full CLEAR/LOAD sequence.

Source files
------------

// File: rtl/ber_run_sequencer.sv
// ber_run_sequencer: run controller for the multi-core BER/FEC system: clear, table load, run to limit, drain, snapshot.
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   start, abort                  run request / terminate current run
//   frame_limit, err_limit        stop limits (0 disables), latched on start
//   tbl_addr, tbl_rd_data         probability table read port (data usable by the next edge)
//   probability_idx/in            system table write port (idx all-ones = no write)
//   sys_en, sys_rstn              system enable / active-low system reset
//   total_*                       live system counters
//   res_*                         counters snapshotted at the end of DRAIN
//   busy, done, aborted           status
module ber_run_sequencer #(
  parameter int N_ENTRIES    = 64,
  parameter int TBL_AW       = 6,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       frame_limit,
  input  logic [63:0]       err_limit,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [63:0]       tbl_rd_data,
  output logic [31:0]       probability_idx,
  output logic [63:0]       probability_in,
  output logic              sys_en,
  output logic              sys_rstn,
  input  logic [63:0]       total_bits,
  input  logic [63:0]       total_bit_errors_pre,
  input  logic [63:0]       total_bit_errors_post,
  input  logic [63:0]       total_frames,
  input  logic [63:0]       total_frame_errors,
  output logic [63:0]       res_bits,
  output logic [63:0]       res_err_pre,
  output logic [63:0]       res_err_post,
  output logic [63:0]       res_frames,
  output logic [63:0]       res_frame_err,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [31:0] cnt, cnt_d, idx_d;
  logic [63:0] flim, elim, pin_d;
  logic [TBL_AW-1:0] addr_d;
  logic last, stop, wr, cap, rstn_d, en_d, busy_d, done_d, aborted_d;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      flim            <= '0;
      elim            <= '0;
      tbl_addr        <= '0;
      probability_idx <= '1;
      probability_in  <= '0;
      sys_en          <= 1'b0;
      sys_rstn        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      res_bits        <= '0;
      res_err_pre     <= '0;
      res_err_post    <= '0;
      res_frames      <= '0;
      res_frame_err   <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      tbl_addr        <= addr_d;
      probability_idx <= idx_d;
      probability_in  <= pin_d;
      sys_en          <= en_d;
      sys_rstn        <= rstn_d;
      busy            <= busy_d;
      done            <= done_d;
      aborted         <= aborted_d;
      if (state == IDLE && start) begin
        flim <= frame_limit;
        elim <= err_limit;
      end
      if (cap) begin
        res_bits      <= total_bits;
        res_err_pre   <= total_bit_errors_pre;
        res_err_post  <= total_bit_errors_post;
        res_frames    <= total_frames;
        res_frame_err <= total_frame_errors;
      end
    end

  // LOAD spans N_ENTRIES+1 cycles: N_ENTRIES address cycles plus the final write cycle
  always_comb begin
    last = state == CLEAR ? cnt == 32'(CLR_CYCLES - 1) :
           state == LOAD  ? cnt == 32'(N_ENTRIES) :
           state == DRAIN ? cnt == 32'(DRAIN_CYCLES - 1) : 1'b0;
    stop = (flim != '0 && total_frames >= flim) || (elim != '0 && total_frame_errors >= elim) || abort;
    state_d = state == IDLE ? (start ? CLEAR : IDLE) :
              (state == CLEAR || state == LOAD) ? (abort ? IDLE : last ? (state == CLEAR ? LOAD : RUN) : state) :
              state == RUN   ? (stop ? DRAIN : RUN) :
              state == DRAIN ? (last ? DONE : DRAIN) : IDLE;
    cnt_d = state_d != state ? '0 : cnt + 32'd1;
  end

  // next values of the registered outputs
  always_comb begin
    wr        = state == LOAD && state_d == LOAD;
    idx_d     = wr ? cnt : '1;
    pin_d     = wr ? tbl_rd_data : probability_in;
    addr_d    = wr && cnt < 32'(N_ENTRIES - 1) ? TBL_AW'(cnt + 32'd1) : '0;
    rstn_d    = state_d != CLEAR;
    en_d      = state_d == RUN;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
    cap       = state == DRAIN && last;
    aborted_d = state == IDLE && start ? 1'b0 :
                (state == CLEAR || state == LOAD || state == RUN) && abort ? 1'b1 : aborted;
  end
endmodule

// File: tb/tb_ber_run_sequencer.sv
// tb_ber_run_sequencer: scoreboard bench for ber_run_sequencer with a frame-counter system model.
module tb_ber_run_sequencer;
  localparam int N = 64;
  typedef struct {
    logic [63:0] fr;
    logic [63:0] fe;
    logic        ab;
  } res_t;

  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, abort = 1'b0, err_mode = 1'b0;
  logic [63:0] frame_limit = '0, err_limit = '0, tbl_rd_data, run_cyc = '0;
  logic [63:0] total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors;
  logic [63:0] res_bits, res_err_pre, res_err_post, res_frames, res_frame_err, probability_in;
  logic [31:0] probability_idx, prev_idx = '1;
  logic [5:0] tbl_addr;
  logic sys_en, sys_rstn, busy, done, aborted, prev_en = 1'b0;
  logic [63:0] tbl [N];
  logic [95:0] wq [$];
  res_t rq [$];
  int n_tests = 0, n_fail = 0, since = 0;

  ber_run_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .frame_limit(frame_limit), .err_limit(err_limit),
    .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data),
    .probability_idx(probability_idx), .probability_in(probability_in),
    .sys_en(sys_en), .sys_rstn(sys_rstn),
    .total_bits(total_bits), .total_bit_errors_pre(total_bit_errors_pre),
    .total_bit_errors_post(total_bit_errors_post), .total_frames(total_frames),
    .total_frame_errors(total_frame_errors),
    .res_bits(res_bits), .res_err_pre(res_err_pre), .res_err_post(res_err_post),
    .res_frames(res_frames), .res_frame_err(res_frame_err),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  assign tbl_rd_data = tbl[tbl_addr];
  always @(posedge clk) run_cyc <= !sys_rstn ? '0 : sys_en ? run_cyc + 64'd1 : run_cyc;
  assign total_frames          = run_cyc;
  assign total_bits            = run_cyc * 64'd100;
  assign total_bit_errors_pre  = run_cyc * 64'd3;
  assign total_bit_errors_post = run_cyc;
  assign total_frame_errors    = err_mode && run_cyc >= 64'd300 ? 64'd5 : 64'd0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int count);
    for (int k = 0; k < count; k++) wq.push_back({32'(k), tbl[k]});
  endtask

  task automatic push_res(input logic [63:0] fr, input logic [63:0] fe, input logic ab);
    res_t r;
    r.fr = fr;
    r.fe = fe;
    r.ab = ab;
    rq.push_back(r);
  endtask

  task automatic run_start(input logic ab);
    int n;
    @(negedge clk);
    start = 1'b1;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n = sys_rstn ? 0 : 1;
    for (int i = 0; i < 10 && !sys_rstn; i++) begin
      @(negedge clk);
      if (!sys_rstn) n++;
    end
    chk("clr_len", 96'(n), 96'd4);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 96'(done), 96'd1);
    repeat (3) @(negedge clk);
    chk("wq_empty", 96'(wq.size()), 96'd0);
    chk("rq_empty", 96'(rq.size()), 96'd0);
    chk("idle_busy", 96'(busy), 96'd0);
  endtask

  task automatic wait_run(input logic [63:0] c);
    for (int i = 0; i < 3000 && run_cyc != c; i++) @(negedge clk);
    if (run_cyc != c) chk("run_timeout", 96'(run_cyc), 96'(c));
  endtask

  // scoreboard: table writes and result snapshots are popped as the DUT produces them
  always @(negedge clk) begin
    logic [95:0] e;
    res_t r;
    if (probability_idx !== '1) begin
      if (wq.size() == 0) chk("wr_unexp", 96'(probability_idx), 96'hFFFFFFFF);
      else begin
        e = wq.pop_front();
        chk("wr", {probability_idx, probability_in}, e);
      end
    end
    if (sys_en && !prev_en) chk("en_rise", 96'(prev_idx), 96'd63);
    since = (!sys_en && prev_en) ? 0 : since + 1;
    if (done) begin
      if (rq.size() == 0) chk("done_unexp", 96'(done), 96'd0);
      else begin
        r = rq.pop_front();
        chk("drain_len", 96'(since), 96'd16);
        chk("res_frames", 96'(res_frames), 96'(r.fr));
        chk("res_bits", 96'(res_bits), 96'(r.fr * 64'd100));
        chk("res_err_pre", 96'(res_err_pre), 96'(r.fr * 64'd3));
        chk("res_err_post", 96'(res_err_post), 96'(r.fr));
        chk("res_frame_err", 96'(res_frame_err), 96'(r.fe));
        chk("aborted", 96'(aborted), 96'(r.ab));
      end
    end
    prev_en = sys_en;
    prev_idx = probability_idx;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idx", 96'(probability_idx), 96'hFFFFFFFF);
    chk("rst_ctl", {sys_en, sys_rstn, busy, done, aborted, tbl_addr}, 96'd0);
    chk("rst_res", 96'(res_frames | res_bits | res_frame_err), 96'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_rstn", {sys_rstn, sys_en, busy}, 96'b100);

    // run 1: frame limit 1000; frames counted while sys_en, so one extra count lands on the stop edge
    for (int i = 0; i < N; i++) tbl[i] = 64'(i * 3);
    frame_limit = 64'd1000;
    err_limit = 64'd0;
    push_wr(N);
    push_res(64'd1001, 64'd0, 1'b0);
    run_start(1'b0);
    wait_done();

    // run 2: frame-error limit 5 reached at run cycle 300
    for (int i = 0; i < N; i++) tbl[i] = 64'(i) * 64'h0123_4567_89AB + 64'd7;
    frame_limit = 64'd0;
    err_limit = 64'd5;
    err_mode = 1'b1;
    push_wr(N);
    push_res(64'd301, 64'd5, 1'b0);
    run_start(1'b0);
    wait_done();

    // run 3: abort while LOAD issues address 20
    err_mode = 1'b0;
    push_wr(20);
    run_start(1'b0);
    for (int i = 0; i < 200 && tbl_addr != 6'd20; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 96'(busy), 96'd0);
    chk("ab_flag", 96'(aborted), 96'd1);
    chk("ab_idx", 96'(probability_idx), 96'hFFFFFFFF);
    chk("ab_res_frames", 96'(res_frames), 96'd301);
    chk("ab_res_ferr", 96'(res_frame_err), 96'd5);
    chk("ab_wq", 96'(wq.size()), 96'd0);
    repeat (20) @(negedge clk);
    chk("ab_stay_idle", 96'(busy), 96'd0);

    // run 4: no limits, abort after 500 run cycles; a start during DRAIN is ignored
    frame_limit = 64'd0;
    err_limit = 64'd0;
    push_wr(N);
    push_res(64'd501, 64'd0, 1'b1);
    run_start(1'b0);
    wait_run(64'd500);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("no_rerun", {busy, sys_rstn}, 96'b01);

    // run 5: asynchronous reset mid-run, then a fresh run started together with abort
    push_wr(N);
    run_start(1'b0);
    wait_run(64'd50);
    #2 rstn = 1'b0;
    #1;
    chk("arst_ctl", {sys_en, sys_rstn, busy, aborted}, 96'd0);
    chk("arst_idx", 96'(probability_idx), 96'hFFFFFFFF);
    chk("arst_res", 96'(res_frames), 96'd0);
    @(negedge clk);
    rstn = 1'b1;
    frame_limit = 64'd10;
    push_wr(N);
    push_res(64'd11, 64'd0, 1'b0);
    run_start(1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
